// File: rtl/rmio_rf_sequencer.sv
// rmio_rf_sequencer
// RF-side sequencer between RF RAM and the executing unit. A transaction
// reads INPUT_NUM rows from RAM into the EU input slots. It then waits a
// fixed EU latency. Finally it copies the OUTPUT_NUM EU result slots back
// into RAM. Only one transaction is in flight at a time.
module rmio_rf_sequencer #(
    parameter int                INPUT_NUM   = 1,
    parameter int                OUTPUT_NUM  = 1,
    parameter int                DATA_W      = 1408,
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] INPUT_ADDR  = '0,
    parameter logic [ADDR_W-1:0] OUTPUT_ADDR = '0,
    parameter int                EU_LAT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] input_data  [INPUT_NUM],
    output logic              input_we    [INPUT_NUM],
    output logic              output_re   [OUTPUT_NUM],
    input  logic [DATA_W-1:0] output_data [OUTPUT_NUM]
);

    // One shared counter indexes LOAD slots, WAIT cycles (0..EU_LAT) and
    // STORE slots, so it must hold the largest of the three ranges.
    localparam int IO_MAX  = (INPUT_NUM > OUTPUT_NUM) ? INPUT_NUM : OUTPUT_NUM;
    localparam int CNT_MAX = (IO_MAX > EU_LAT + 1) ? IO_MAX : EU_LAT + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        STORE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Read-return pipeline: a read issued in one cycle has data on
    // ram_rdata in the next cycle. That data is captured at the end of it.
    logic               rd_vld_q;
    logic [CNT_W-1:0]   rd_idx_q;
    logic [DATA_W-1:0]  input_data_q [INPUT_NUM];
    logic               input_we_q   [INPUT_NUM];

    // State register and the shared slot/latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples the
            // pre-edge values; a blocking '=' here would create ordering races.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. WAIT lasts EU_LAT+1 cycles. The last input_we
    // happens two cycles after the last LOAD cycle. Therefore the first
    // STORE cycle comes exactly EU_LAT cycles after that last input_we.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; missing
        // ones would infer latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_W'(INPUT_NUM - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(EU_LAT)) begin
                    state_d = STORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STORE: begin
                if (cnt_q == CNT_W'(OUTPUT_NUM - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode. RAM strobes are mutually exclusive by state. The
    // address wraps naturally at ADDR_W bits. Store data passes straight
    // through from the selected EU slot.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        for (int k = 0; k < OUTPUT_NUM; k++) begin
            output_re[k] = 1'b0;
        end
        unique case (state_q)
            LOAD: begin
                busy     = 1'b1;
                ram_re   = 1'b1;
                ram_addr = INPUT_ADDR + ADDR_W'(cnt_q);
            end
            WAIT: begin
                busy = 1'b1;
            end
            STORE: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = OUTPUT_ADDR + ADDR_W'(cnt_q);
                for (int k = 0; k < OUTPUT_NUM; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        output_re[k] = 1'b1;
                        ram_wdata    = output_data[k];
                    end
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture returning RAM rows into the EU input slots and pulse the
    // matching write strobe for one cycle. Reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            // NOTE: input_data is a small bank of output registers, not a
            // RAM, so clearing it in reset is cheap and gives the EU a
            // defined value.
            for (int i = 0; i < INPUT_NUM; i++) begin
                input_data_q[i] <= '0;
                input_we_q[i]   <= 1'b0;
            end
        end else begin
            rd_vld_q <= (state_q == LOAD);
            rd_idx_q <= cnt_q;
            for (int i = 0; i < INPUT_NUM; i++) begin
                input_we_q[i] <= rd_vld_q && (rd_idx_q == CNT_W'(i));
                if (rd_vld_q && (rd_idx_q == CNT_W'(i))) begin
                    input_data_q[i] <= ram_rdata;
                end
            end
        end
    end

    assign input_data = input_data_q;
    assign input_we   = input_we_q;

endmodule
